fpmult_state_i: RTL and testbench

//  Iterative shift-and-add fixed-point multiplier built around a state record
//  {acc, counter}: one multiplier bit is consumed per cycle. Computes c = a*b in
//  Qn-d.d format (integer product of the raw words, shifted right by d bits).

---
 rtl/fpmult_pkg.sv | 21 ++
 rtl/fpmult_step.sv | 38 +++
 rtl/fpmult_state_i.sv | 85 ++++++++
 tb/tb_fpmult_state_i.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fpmult_pkg.sv
// Shared types for the iterative fixed-point multiplier.
// Holds the {acc, counter} state record and the handshake FSM encoding.
package fpmult_pkg;

  localparam int FP_N  = 32;
  localparam int FP_D  = 16;
  localparam int ACC_W = FP_N + FP_D;
  localparam int CNT_W = $clog2(FP_N + 1);

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] counter;
  } state_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fsm_e;

endpackage

// File: rtl/fpmult_step.sv
// One shift-and-add iteration: consumes multiplier bit hb[counter].
// Purely combinational; the top registers the returned state.
module fpmult_step
  import fpmult_pkg::*;
#(
  parameter int N    = FP_N,
  parameter int D    = FP_D,
  parameter int SIGN = 1
) (
  input  logic [ACC_W-1:0] ha,
  input  logic [N-1:0]     hb,
  input  state_t           cur,
  output state_t           nxt,
  output logic             last
);

  logic [$clog2(N)-1:0] w_idx;
  logic [ACC_W-1:0]     w_shifted;
  logic [ACC_W-1:0]     w_pp;
  logic                 w_neg;

  assign w_idx     = cur.counter[$clog2(N)-1:0];
  assign w_shifted = ha << cur.counter;
  assign last      = (cur.counter == CNT_W'(N - 1));
  // The sign bit of a two's-complement multiplier carries weight -2^(N-1).
  assign w_neg     = (SIGN != 0) && last && hb[N-1];

  always_comb begin
    w_pp = '0;
    if (hb[w_idx]) begin
      w_pp = w_neg ? (-w_shifted) : w_shifted;
    end
  end

  assign nxt.acc     = cur.acc + w_pp;
  assign nxt.counter = cur.counter + CNT_W'(1);

endmodule

// File: rtl/fpmult_state_i.sv
// Iterative Q(N-D).D multiplier behind a val/rdy stream interface.
// One multiplier bit per cycle; result valid N cycles after the accept edge.
module fpmult_state_i
  import fpmult_pkg::*;
#(
  parameter int N    = FP_N,
  parameter int D    = FP_D,
  parameter int SIGN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [N-1:0] c
);

  fsm_e             r_fsm;
  state_t           r_state;
  logic [ACC_W-1:0] r_ha;
  logic [N-1:0]     r_hb;

  state_t           w_nxt;
  logic             w_last;
  logic [ACC_W-1:0] w_ext;

  assign w_ext = {{D{(SIGN != 0) & a[N-1]}}, a};

  fpmult_step #(
    .N    (N),
    .D    (D),
    .SIGN (SIGN)
  ) u_step (
    .ha   (r_ha),
    .hb   (r_hb),
    .cur  (r_state),
    .nxt  (w_nxt),
    .last (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm    <= IDLE;
      r_state  <= '0;
      r_ha     <= '0;
      r_hb     <= '0;
      recv_rdy <= 1'b1;
      send_val <= 1'b0;
      c        <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (recv_val && recv_rdy) begin
            r_ha     <= w_ext;
            r_hb     <= b;
            r_state  <= '0;
            recv_rdy <= 1'b0;
            r_fsm    <= CALC;
          end
        end
        CALC: begin
          r_state <= w_nxt;
          if (w_last) begin
            // Drop the D fraction bits: floor toward -inf, wrap the integer part.
            c        <= w_nxt.acc[ACC_W-1:D];
            send_val <= 1'b1;
            r_fsm    <= DONE;
          end
        end
        DONE: begin
          if (send_val && send_rdy) begin
            send_val <= 1'b0;
            recv_rdy <= 1'b1;
            r_fsm    <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmult_state_i.sv
// Bench for fpmult_state_i: a signed and an unsigned instance, directed and
// random operations checked against an arithmetic product model.
module tb_fpmult_state_i;

  logic        clk;
  logic        reset;
  logic        rv [2];
  logic        rr [2];
  logic [31:0] a  [2];
  logic [31:0] b  [2];
  logic        sv [2];
  logic        sr [2];
  logic [31:0] c  [2];

  int n_vec;
  int n_err;

  fpmult_state_i #(.N(32), .D(16), .SIGN(1)) dut_s (
    .clk(clk), .reset(reset),
    .recv_val(rv[0]), .recv_rdy(rr[0]), .a(a[0]), .b(b[0]),
    .send_val(sv[0]), .send_rdy(sr[0]), .c(c[0])
  );

  fpmult_state_i #(.N(32), .D(16), .SIGN(0)) dut_u (
    .clk(clk), .reset(reset),
    .recv_val(rv[1]), .recv_rdy(rr[1]), .a(a[1]), .b(b[1]),
    .send_val(sv[1]), .send_rdy(sr[1]), .c(c[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Product of the raw words as an integer, scaled down by 2^16 with floor,
  // then wrapped to 32 bits.
  function automatic logic [31:0] model(input int u, input logic [31:0] x, input logic [31:0] y);
    longint          p;
    longint unsigned q;
    if (u == 0) begin
      p = longint'(signed'(x)) * longint'(signed'(y));
      p = p >>> 16;
      return p[31:0];
    end
    q = {32'b0, x} * {32'b0, y};
    q = q >> 16;
    return q[31:0];
  endfunction

  task automatic run_op(input int u, input logic [31:0] ia, input logic [31:0] ib,
                        input int hold, input logic [31:0] exp);
    int cyc;
    bit seen;
    @(negedge clk);
    check("recv_rdy_idle", 32'(rr[u]), 32'd1);
    a[u]  = ia;
    b[u]  = ib;
    rv[u] = 1'b1;
    @(posedge clk);
    #1;
    rv[u] = 1'b0;
    a[u]  = $urandom;
    b[u]  = $urandom;
    check("recv_rdy_busy", 32'(rr[u]), 32'd0);
    seen = 1'b0;
    for (cyc = 1; cyc <= 64; cyc++) begin
      @(posedge clk);
      #1;
      if (sv[u]) begin
        seen = 1'b1;
        break;
      end
    end
    check("latency", seen ? 32'(cyc) : 32'd0, 32'd32);
    check("product", c[u], exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      rv[u] = 1'($urandom_range(0, 1));
      a[u]  = $urandom;
      b[u]  = $urandom;
      @(posedge clk);
      #1;
      check("hold_send_val", 32'(sv[u]), 32'd1);
      check("hold_c", c[u], exp);
      check("hold_recv_rdy", 32'(rr[u]), 32'd0);
    end
    @(negedge clk);
    rv[u] = 1'b0;
    sr[u] = 1'b1;
    @(posedge clk);
    #1;
    sr[u] = 1'b0;
    check("drain_send_val", 32'(sv[u]), 32'd0);
    check("drain_recv_rdy", 32'(rr[u]), 32'd1);
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rv[u] = 1'b0;
      sr[u] = 1'b0;
      a[u]  = '0;
      b[u]  = '0;
    end
    #22;
    for (int u = 0; u < 2; u++) begin
      check("rst_recv_rdy", 32'(rr[u]), 32'd1);
      check("rst_send_val", 32'(sv[u]), 32'd0);
      check("rst_c", c[u], 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    run_op(0, 32'h0001_8000, 32'h0002_0000, 0, 32'h0003_0000);
    run_op(0, 32'hFFFE_8000, 32'h0002_0000, 0, 32'hFFFD_0000);
    run_op(0, 32'h0002_0000, 32'hFFFE_8000, 0, 32'hFFFD_0000);
    run_op(0, 32'hFFFF_FFFF, 32'h0000_8000, 0, 32'hFFFF_FFFF);
    run_op(0, 32'h0000_0001, 32'h0000_8000, 0, 32'h0000_0000);
    run_op(1, 32'hFFFF_0000, 32'h0001_0000, 0, 32'hFFFF_0000);
    run_op(1, 32'h0000_8000, 32'h0000_8000, 0, 32'h0000_4000);
    run_op(0, 32'h8000_0000, 32'h8000_0000, 3, model(0, 32'h8000_0000, 32'h8000_0000));
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, model(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF));

    // Backpressure on the signed instance.
    run_op(0, 32'h0001_8000, 32'h0002_0000, 10, 32'h0003_0000);

    for (int k = 0; k < 24; k++) begin
      int u;
      u = k % 2;
      x = $urandom;
      y = $urandom;
      if (k % 4 == 1) x = x >>> $urandom_range(0, 24);
      run_op(u, x, y, int'($urandom_range(0, 3)), model(u, x, y));
    end

    // Abort mid-calculation with an asynchronous reset.
    @(negedge clk);
    a[0]  = 32'h0003_0000;
    b[0]  = 32'h0005_0000;
    rv[0] = 1'b1;
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_recv_rdy", 32'(rr[0]), 32'd1);
    check("abort_send_val", 32'(sv[0]), 32'd0);
    check("abort_c", c[0], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0001_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
